timer_ctrl: RTL and testbench

Front-end control stage for the stopwatch counter chain. It sits directly upstream of the seconds counter and drives that chain's count-enable input.
- Synchronises and debounces two push-buttons: start/stop and clear.
- Runs an IDLE/RUN/PAUSE state machine.
- Divides the system clock into one-cycle count ticks, emitted only while running.
- Issues a one-cycle clear pulse to the counter chain.

---
 rtl/timer_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl -- front-end control stage for the stopwatch counter chain.
//
// Synchronises and debounces the start/stop and clear push-buttons. It runs an
// IDLE/RUN/PAUSE state machine and divides clk into one-cycle count ticks,
// which are emitted only while running. It also issues a one-cycle clear pulse
// to the counter chain.
//
// Optional feature (macro TIMER_LAP_EN): adds a lap button that toggles a
// display-freeze "hold" flag while running.
//
// Parameters:
//   TICK_DIV  - clk cycles per count tick (>= 2)
//   DB_CYCLES - consecutive stable cycles to accept a button change (>= 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   btn_ss   in   raw start/stop button (asynchronous, active-high)
//   btn_clr  in   raw clear button (asynchronous, active-high)
//   btn_lap  in   raw lap button (TIMER_LAP_EN only)
//   hold     out  display hold flag (TIMER_LAP_EN only)
//   tick     out  one-cycle count-enable pulse to the seconds counter
//   clr      out  one-cycle clear pulse to the counter chain
//   running  out  high while state is RUN
//   state    out  00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
`ifdef TIMER_LAP_EN
    input  logic       btn_lap,
    output logic       hold,
`endif
    output logic       tick,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);

    localparam int B_SS  = 0;
    localparam int B_CLR = 1;
`ifdef TIMER_LAP_EN
    localparam int B_LAP = 2;
    localparam int NBTN  = 3;
`else
    localparam int NBTN  = 2;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press;

`ifdef TIMER_LAP_EN
    assign btn_raw = {btn_lap, btn_clr, btn_ss};
`else
    assign btn_raw = {btn_clr, btn_ss};
`endif

    // -------------------------------------------------------------------------
    // Per-button input path: 2-flop synchroniser, debounce counter, and a
    // registered rising-edge detect. The edge detect works on a delayed copy
    // of the debounced level, so the press pulse lands DB_CYCLES+3 edges
    // after the raw rise.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          level_d1_reg;
            logic          level_d2_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    level_reg    <= 1'b0;
                    level_d1_reg <= 1'b0;
                    level_d2_reg <= 1'b0;
                    press_reg    <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;

                    // Any agreement between the synchronised input and the
                    // accepted level restarts the stability count.
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_MAX) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end

                    level_d1_reg <= level_reg;
                    level_d2_reg <= level_d1_reg;
                    press_reg    <= level_d1_reg & ~level_d2_reg;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic ss_press;
    logic clr_press;
    assign ss_press  = press[B_SS];
    assign clr_press = press[B_CLR];

`ifdef TIMER_LAP_EN
    logic lap_press;
    logic hold_reg;
    assign lap_press = press[B_LAP];
    assign hold      = hold_reg;
`endif

    // -------------------------------------------------------------------------
    // State machine, prescaler and registered outputs.
    // Tick and prescaler updates are decided from the pre-edge state. A
    // prescaler wrap on the same edge that leaves RUN therefore still
    // produces its tick.
    // -------------------------------------------------------------------------
    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic          tick_reg;
    logic          clr_reg;
    logic          running_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            presc_reg   <= '0;
            tick_reg    <= 1'b0;
            clr_reg     <= 1'b0;
            running_reg <= 1'b0;
`ifdef TIMER_LAP_EN
            hold_reg    <= 1'b0;
`endif
        end else begin
            tick_reg <= (state_reg == S_RUN) && (presc_reg == PRESC_MAX);
            clr_reg  <= clr_press;

            case (state_reg)
                S_RUN:   presc_reg <= (presc_reg == PRESC_MAX) ? '0 : presc_reg + PW'(1);
                S_PAUSE: presc_reg <= presc_reg;   // keep the partial second
                default: presc_reg <= '0;
            endcase

            // Clear has priority; a simultaneous start/stop press is dropped.
            if (clr_press) begin
                state_reg   <= S_IDLE;
                running_reg <= 1'b0;
            end else if (ss_press) begin
                case (state_reg)
                    S_RUN: begin
                        state_reg   <= S_PAUSE;
                        running_reg <= 1'b0;
                    end
                    default: begin
                        state_reg   <= S_RUN;
                        running_reg <= 1'b1;
                    end
                endcase
            end

`ifdef TIMER_LAP_EN
            if (clr_press) begin
                hold_reg <= 1'b0;
            end else if (lap_press && state_reg == S_RUN) begin
                hold_reg <= ~hold_reg;
            end
`endif
        end
    end

    assign tick    = tick_reg;
    assign clr     = clr_reg;
    assign running = running_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl -- self-checking bench for timer_ctrl (TICK_DIV=10,
// DB_CYCLES=4). A behavioural reference model derives button presses from the
// raw input history. A button's accepted level flips once the synchronised
// samples have disagreed with it for DB_CYCLES edges in a row, and the FSM
// sees the press three edges later. Every cycle the model predicts tick, clr,
// running, state (and hold when TIMER_LAP_EN is defined).
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic       tick;
    logic       clr;
    logic       running;
    logic [1:0] state;
`ifdef TIMER_LAP_EN
    logic       hold;
`endif

    always #5 clk = ~clk;

    timer_ctrl #(
        .TICK_DIV  (TD),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
`ifdef TIMER_LAP_EN
        .btn_lap (btn_lap),
        .hold    (hold),
`endif
        .tick    (tick),
        .clr     (clr),
        .running (running),
        .state   (state)
    );

    int pass_cnt = 0;
    int total    = 0;
    int n_tick;
    int n_clr;

    // Reference model state
    bit hist [3][32];   // raw samples, [0] = newest edge
    bit rose [3][8];    // accepted-level rising events, [0] = previous edge
    bit lvl  [3];
    int m_state;        // 0 IDLE, 1 RUN, 2 PAUSE
    int m_presc;        // RUN cycles into the current second
    bit m_tick;
    bit m_clr;
    bit m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            lvl[b] = 1'b0;
            for (int i = 0; i < 32; i++) hist[b][i] = 1'b0;
            for (int i = 0; i < 8; i++) rose[b][i] = 1'b0;
        end
        m_state = 0;
        m_presc = 0;
        m_tick  = 1'b0;
        m_clr   = 1'b0;
        m_hold  = 1'b0;
    endtask

    // One clock: advance the model at the rising edge, compare at the falling edge.
    task automatic step();
        bit raw [3];
        bit prs [3];
        bit all_diff;
        bit new_rise;
        @(posedge clk);
        raw[0] = btn_ss;
        raw[1] = btn_clr;
        raw[2] = btn_lap;
        if (rst) begin
            model_reset();
        end else begin
            for (int b = 0; b < 3; b++) prs[b] = rose[b][2];
            m_tick = (m_state == 1) && (m_presc == TD - 1);
            m_clr  = prs[1];
            if (m_state == 1)      m_presc = (m_presc + 1) % TD;
            else if (m_state == 0) m_presc = 0;
            if (prs[1]) begin
                m_state = 0;
                m_hold  = 1'b0;
            end else begin
                if (prs[2] && m_state == 1) m_hold = !m_hold;
                if (prs[0]) m_state = (m_state == 1) ? 2 : 1;
            end
            for (int b = 0; b < 3; b++) begin
                for (int i = 31; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
                // synchronised value at this edge is the raw sample two edges old
                all_diff = 1'b1;
                for (int i = 2; i < 2 + DB; i++) if (hist[b][i] == lvl[b]) all_diff = 1'b0;
                new_rise = all_diff && !lvl[b];
                if (all_diff) lvl[b] = !lvl[b];
                for (int i = 7; i > 0; i--) rose[b][i] = rose[b][i-1];
                rose[b][0] = new_rise;
            end
        end
        @(negedge clk);
        if (tick === 1'b1) n_tick++;
        if (clr === 1'b1)  n_clr++;
        check("tick",    32'(tick),    32'(m_tick));
        check("clr",     32'(clr),     32'(m_clr));
        check("running", 32'(running), 32'(m_state == 1));
        check("state",   32'(state),   32'(m_state));
`ifdef TIMER_LAP_EN
        check("hold",    32'(hold),    32'(m_hold));
`endif
    endtask

    task automatic pulse(input bit ss, input bit cl, input bit lp, input int hi, input int lo);
        n_tick  = 0;
        n_clr   = 0;
        btn_ss  = ss;
        btn_clr = cl;
        btn_lap = lp;
        repeat (hi) step();
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        repeat (lo) step();
        $display("pulse ss=%0b clr=%0b lap=%0b hi=%0d lo=%0d -> state=%0d ticks=%0d clrs=%0d",
                 ss, cl, lp, hi, lo, state, n_tick, n_clr);
    endtask

    initial begin
        int k;
        int lat;
        int nt;

        rst     = 1'b1;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        n_tick  = 0;
        n_clr   = 0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;

        // idle after reset
        pulse(1'b0, 1'b0, 1'b0, 0, 50);
        check("idle_ticks", 32'(n_tick), 32'd0);

        // short glitch is rejected
        pulse(1'b1, 1'b0, 1'b0, 3, 20);
        check("glitch_state", 32'(state), 32'd0);

        // start: latency and tick cadence
        btn_ss = 1'b1;
        k   = 0;
        lat = 0;
        nt  = 0;
        while (k < 200 && (lat == 0 || k < lat + 50)) begin
            if (k == 20) btn_ss = 1'b0;
            step();
            k++;
            if (lat == 0 && state === 2'b01) lat = k;
            else if (lat != 0 && tick === 1'b1) nt++;
        end
        btn_ss = 1'b0;
        $display("start: edges_to_run=%0d ticks_in_50=%0d", lat - 1, nt);
        check("ss_latency", 32'(lat - 1), 32'(DB + 4));
        check("ticks_in_50", 32'(nt), 32'd5);

        // pause, hold for 100 cycles, resume with partial second
        pulse(1'b1, 1'b0, 1'b0, 8, 100);
        check("pause_state", 32'(state), 32'd2);
        pulse(1'b1, 1'b0, 1'b0, 8, 40);
        check("resume_state", 32'(state), 32'd1);

        // pause, then clear + start/stop together: clear wins
        pulse(1'b1, 1'b0, 1'b0, 8, 30);
        pulse(1'b1, 1'b1, 1'b0, 8, 30);
        check("clr_wins_state", 32'(state), 32'd0);
        check("clr_single", 32'(n_clr), 32'd1);

        // fresh start, clear while running, clear while idle
        pulse(1'b1, 1'b0, 1'b0, 8, 40);
        pulse(1'b0, 1'b1, 1'b0, 8, 20);
        pulse(1'b0, 1'b1, 1'b0, 8, 20);
        check("clr_idle_pulse", 32'(n_clr), 32'd1);

        // reset in the middle of a second
        pulse(1'b1, 1'b0, 1'b0, 8, 15);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 0, 20);
        check("post_rst_state", 32'(state), 32'd0);

`ifdef TIMER_LAP_EN
        pulse(1'b1, 1'b0, 1'b0, 8, 15);
        pulse(1'b0, 1'b0, 1'b1, 8, 30);
        check("lap_on", 32'(hold), 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 8, 30);
        check("lap_off", 32'(hold), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 8, 20);
        pulse(1'b1, 1'b0, 1'b0, 8, 20);
        pulse(1'b0, 1'b0, 1'b1, 8, 20);
        check("lap_pause", 32'(hold), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 8, 20);
        check("lap_clr", 32'(hold), 32'd0);
`endif

        // randomized button activity
        for (int r = 0; r < 40; r++) begin
            int m;
            m = $urandom_range(1, 7);
            pulse(m[0], m[1], m[2], $urandom_range(1, 12), $urandom_range(1, 25));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
